// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use and branch hazards,
// the data-memory req/ack handshake with timeout, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             timeout_err,
    output logic [CNT_W-1:0] perf_stall_cnt
);

    localparam int unsigned TO_W = 8;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_nxt;
    logic            timeout_hit;
    logic            mem_op;
    logic            mem_stall;
    logic            load_use;
    logic            lu_stall;

    assign mem_op = mem_read | mem_write;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // A taken branch squashes the ID instruction, so its load-use stall is moot.
    assign lu_stall = load_use & ~ex_branch_taken;

    // Handshake: next state, timeout counter and the freeze request.
    always_comb begin
        state_nxt   = state;
        to_cnt_nxt  = to_cnt;
        timeout_hit = 1'b0;
        mem_stall   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_op && !dmem_ack) begin
                    mem_stall  = 1'b1;
                    state_nxt  = ST_WAIT;
                    to_cnt_nxt = TO_W'(1);
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    state_nxt  = ST_IDLE;
                    to_cnt_nxt = '0;
                end else if (to_cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_IDLE;
                    to_cnt_nxt  = '0;
                end else begin
                    mem_stall  = 1'b1;
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                to_cnt_nxt = '0;
            end
        endcase
    end

    // Pipeline-register controls; memory freeze overrides branch, branch overrides load-use.
    always_comb begin
        dmem_req      = 1'b0;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!rst) begin
            dmem_req = (state == ST_WAIT) ? 1'b1 : mem_op;
            if (mem_stall) begin
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_en      = 1'b0;
                ex_mem_en     = 1'b0;
                mem_wb_bubble = 1'b1;
            end else if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            to_cnt         <= '0;
            timeout_err    <= 1'b0;
            perf_stall_cnt <= '0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
            if ((mem_stall || lu_stall) && (perf_stall_cnt != {CNT_W{1'b1}})) begin
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
